muldiv_hilo: RTL



---
 rtl/muldiv_hilo_pkg.sv | 31 +++
 rtl/muldiv_hilo_if.sv | 26 ++
 rtl/muldiv_hilo_div_radix2.sv | 114 +++++++++++
 rtl/muldiv_hilo.sv | 135 +++++++++++++
 4 files changed

// File: rtl/muldiv_hilo_pkg.sv
// Shared types for the multiply/divide unit: operation codes seen by decode
// and the EXE stage register, the unit's FSM states, and a magnitude helper.
package muldiv_hilo_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // Final iteration index of the 32-step divider.
    localparam logic [4:0] DIV_LAST_COUNT = 5'd31;

    // Magnitude of a 32-bit operand; only negates when treated as signed.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// EXE-stage <-> multiply/divide unit signal bundle.
interface muldiv_hilo_if;
    import muldiv_hilo_pkg::*;

    logic        EXE_Valid;
    muldiv_op_e  EXE_MulDivOp;
    logic [31:0] EXE_A;
    logic [31:0] EXE_B;
    logic        EXE_Hold;
    logic        EXE_Flush;
    logic        MulDiv_StallReq;
    logic [31:0] HI;
    logic [31:0] LO;

    // EXE stage side.
    modport master (
        output EXE_Valid, EXE_MulDivOp, EXE_A, EXE_B, EXE_Hold, EXE_Flush,
        input  MulDiv_StallReq, HI, LO
    );

    // Multiply/divide unit side.
    modport slave (
        input  EXE_Valid, EXE_MulDivOp, EXE_A, EXE_B, EXE_Hold, EXE_Flush,
        output MulDiv_StallReq, HI, LO
    );
endinterface

// File: rtl/muldiv_hilo_div_radix2.sv
// Iterative radix-2 restoring divider on operand magnitudes. One quotient bit
// per cycle for 32 cycles; the last-cycle outputs already include the final
// step, sign fixup and the divide-by-zero special case.
module div_radix2
    import muldiv_hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);

    logic        busy_q,  busy_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] quo_q,   quo_d;     // dividend bits shift out, quotient bits shift in
    logic [31:0] rem_q,   rem_d;     // partial remainder
    logic [31:0] dvsr_q,  dvsr_d;    // divisor magnitude
    logic [31:0] a_raw_q, a_raw_d;   // original dividend for divide-by-zero
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        zero_q,  zero_d;

    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] quo_step;
    logic [31:0] rem_step;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        diff      = rem_shift - {1'b0, dvsr_q};
        if (!diff[32]) begin
            rem_step = diff[31:0];
            quo_step = {quo_q[30:0], 1'b1};
        end else begin
            rem_step = rem_shift[31:0];
            quo_step = {quo_q[30:0], 1'b0};
        end
    end

    // Result outputs: zero divisor bypasses the sign fixup entirely.
    always_comb begin
        last      = busy_q && (count_q == DIV_LAST_COUNT);
        quotient  = zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? (~quo_step + 32'd1) : quo_step);
        remainder = zero_q ? a_raw_q       : (neg_rem_q ? (~rem_step + 32'd1) : rem_step);
    end

    // Next-state: load on start, iterate while busy, flush aborts.
    always_comb begin
        busy_d    = busy_q;
        count_d   = count_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        a_raw_d   = a_raw_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        if (start) begin
            busy_d    = 1'b1;
            count_d   = 5'd0;
            quo_d     = mag32(a, is_signed);
            rem_d     = 32'd0;
            dvsr_d    = mag32(b, is_signed);
            a_raw_d   = a;
            neg_quo_d = is_signed && (a[31] ^ b[31]);
            neg_rem_d = is_signed && a[31];
            zero_d    = (b == 32'd0);
        end else if (busy_q) begin
            quo_d   = quo_step;
            rem_d   = rem_step;
            count_d = count_q + 5'd1;
            if (count_q == DIV_LAST_COUNT) begin
                busy_d = 1'b0;
            end
        end
        if (flush) begin
            busy_d  = 1'b0;
            count_d = 5'd0;
        end
    end

    // Divider registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q    <= 1'b0;
            count_q   <= 5'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            a_raw_q   <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            count_q   <= count_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            a_raw_q   <= a_raw_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// Multiply/divide unit owning HI/LO. Results commit before the issuing
// instruction leaves EXE, so HI/LO readers in EXE never need a bypass.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    muldiv_hilo_if.slave  bus
);

    muldiv_state_e state_q, state_d;
    logic [31:0]   hi_q,    hi_d;
    logic [31:0]   lo_q,    lo_d;
    logic [31:0]   op_a_q,  op_a_d;
    logic [31:0]   op_b_q,  op_b_d;
    logic          mul_signed_q, mul_signed_d;

    logic          stall_req;
    logic          div_start;
    logic          accept;
    logic [63:0]   ext_a;
    logic [63:0]   ext_b;
    logic [63:0]   product;
    logic [31:0]   div_quo;
    logic [31:0]   div_rem;
    logic          div_last;

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .is_signed (bus.EXE_MulDivOp == OP_DIV),
        .a         (bus.EXE_A),
        .b         (bus.EXE_B),
        .flush     (bus.EXE_Flush),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    // 64-bit product from latched operands; the low 64 bits of a wide
    // product of sign/zero-extended operands serve both MULT and MULTU.
    always_comb begin
        ext_a   = mul_signed_q ? {{32{op_a_q[31]}}, op_a_q} : {32'd0, op_a_q};
        ext_b   = mul_signed_q ? {{32{op_b_q[31]}}, op_b_q} : {32'd0, op_b_q};
        product = ext_a * ext_b;
    end

    // FSM next state, HI/LO writes and stall request; flush overrides all.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        mul_signed_d = mul_signed_q;
        stall_req    = 1'b0;
        div_start    = 1'b0;
        accept       = bus.EXE_Valid && !bus.EXE_Flush;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.EXE_MulDivOp)
                        OP_MULT, OP_MULTU: begin
                            op_a_d       = bus.EXE_A;
                            op_b_d       = bus.EXE_B;
                            mul_signed_d = (bus.EXE_MulDivOp == OP_MULT);
                            state_d      = ST_MUL;
                            stall_req    = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            div_start = 1'b1;
                            state_d   = ST_DIV;
                            stall_req = 1'b1;
                        end
                        OP_MTHI: hi_d = bus.EXE_A;
                        OP_MTLO: lo_d = bus.EXE_A;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                stall_req = 1'b1;
                hi_d      = product[63:32];
                lo_d      = product[31:0];
                state_d   = ST_DONE;
            end
            ST_DIV: begin
                stall_req = 1'b1;
                if (div_last) begin
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.EXE_Hold) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.EXE_Flush) begin
            state_d   = ST_IDLE;
            stall_req = 1'b0;
            div_start = 1'b0;
            hi_d      = hi_q;
            lo_d      = lo_q;
        end
    end

    // State and architectural registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            mul_signed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            mul_signed_q <= mul_signed_d;
        end
    end

    assign bus.MulDiv_StallReq = stall_req;
    assign bus.HI              = hi_q;
    assign bus.LO              = lo_q;

endmodule
